// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------
// seq_pkg : shared constants and state type for the 1011 sync link
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package seq_pkg;

  localparam int              PRE_W         = 4;
  localparam logic [PRE_W-1:0] PREAMBLE     = 4'b1011;
  localparam logic [2:0]      STUFF_TRIGGER = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_frame_tx_if.sv
// ---------------------------------------------------------------
// seq_frame_tx_if : word handshake in, serial frame line out
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface seq_frame_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              out;
  logic              out_valid;
  logic              out_stuff;
  logic              frame_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, out, out_valid, out_stuff, frame_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, out, out_valid, out_stuff, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/seq_stuff_hist.sv
// ---------------------------------------------------------------
// seq_stuff_hist : history of the last 3 emitted bits, flags 101
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module seq_stuff_hist
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic bit_in,
  input  logic clr,
  output logic stuff_req
);

  logic [2:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clr)
      hist_d = 3'b000;
    else if (shift_en)
      hist_d = {hist_q[1:0], bit_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hist_q <= 3'b000;
    else
      hist_q <= hist_d;
  end

  assign stuff_req = (hist_q == STUFF_TRIGGER);

endmodule

`default_nettype wire

// File: rtl/seq_frame_tx.sv
// ---------------------------------------------------------------
// seq_frame_tx : preamble + MSB-first payload with 0-bit stuffing
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_frame_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]        pre_cnt_q, pre_cnt_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_stuff_q, out_stuff_d;
  logic              frame_done_q, frame_done_d;
  logic              hist_clr;
  logic              stuff_req;
  logic [1:0]        pre_idx;

  // pre_cnt_q names the preamble bit currently on the line; pre_idx is the next one
  assign pre_idx = 2'(PRE_W - 2) - pre_cnt_q;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    pre_cnt_d    = pre_cnt_q;
    out_d        = 1'b0;
    out_valid_d  = 1'b0;
    out_stuff_d  = 1'b0;
    frame_done_d = 1'b0;
    hist_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.data_valid) begin
          state_d     = S_PRE;
          shreg_d     = bus.data_in;
          pre_cnt_d   = 2'd0;
          bit_cnt_d   = '0;
          out_d       = PREAMBLE[PRE_W-1];
          out_valid_d = 1'b1;
        end
      end
      S_PRE: begin
        out_valid_d = 1'b1;
        if (pre_cnt_q == 2'(PRE_W - 1)) begin
          // history after the preamble is x11, so the first payload bit is never stuffed
          state_d   = S_DATA;
          out_d     = shreg_q[DATA_W-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = CNT_W'(1);
        end else begin
          pre_cnt_d = pre_cnt_q + 2'd1;
          out_d     = PREAMBLE[pre_idx];
        end
      end
      S_DATA: begin
        if (stuff_req) begin
          out_valid_d = 1'b1;
          out_stuff_d = 1'b1;
        end else if (bit_cnt_q == CNT_W'(DATA_W)) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          hist_clr     = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_d       = shreg_q[DATA_W-1];
          shreg_d     = shreg_q << 1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      pre_cnt_q    <= 2'd0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_stuff_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      out_stuff_q  <= out_stuff_d;
      frame_done_q <= frame_done_d;
    end
  end

  // History advances in step with the out register, so it always holds the last 3 line bits
  seq_stuff_hist u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (out_valid_d),
    .bit_in    (out_d),
    .clr       (hist_clr),
    .stuff_req (stuff_req)
  );

  assign bus.data_ready = (state_q == S_IDLE);
  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_stuff  = out_stuff_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
// ---------------------------------------------------------------
// tb_seq_frame_tx : scoreboard bench for seq_frame_tx (DATA_W=8)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_seq_frame_tx;

  typedef struct {
    logic done;
    logic b;
    logic s;
    int   len;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   det_count;
  int   pos;
  logic in_frame;
  logic [3:0] det_hist;
  exp_t q[$];

  seq_frame_tx_if #(.DATA_W(8)) bus ();

  seq_frame_tx #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line image is MSB first; bit len-1 goes out first
  task automatic push_frame(input logic [15:0] bits, input logic [15:0] stf, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.done = 1'b0;
      e.b    = bits[len-1-k];
      e.s    = stf[len-1-k];
      e.len  = 0;
      q.push_back(e);
    end
    e.done = 1'b1;
    e.b    = 1'b0;
    e.s    = 1'b0;
    e.len  = len;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.data_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, bus.data_ready}, 32'd1);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.data_in    = 8'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++)
      @(posedge clk);
    check("drain", q.size(), 32'd0);
  endtask

  // Monitor: scoreboard compare plus a loopback overlapping 1011 detector on valid bits
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_frame = 1'b0;
      pos      = 0;
      det_hist = 4'b0000;
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_bit", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("bit_not_done", {31'd0, e.done}, 32'd0);
        check("line_bit", {29'd0, bus.out, bus.out_stuff, bus.frame_done}, {29'd0, e.b, e.s, 1'b0});
      end
      pos++;
      in_frame = 1'b1;
      det_hist = {det_hist[2:0], bus.out};
      if (det_hist == 4'b1011) begin
        det_count++;
        check("detect_pos", pos, 32'd4);
      end
    end else begin
      check("idle_line", {30'd0, bus.out, bus.out_stuff}, 32'd0);
      if (bus.frame_done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("done_expected", {31'd0, e.done}, 32'd1);
          check("frame_len", pos, e.len);
        end
        in_frame = 1'b0;
        pos      = 0;
      end else if (in_frame) begin
        check("frame_gap", 32'd1, 32'd0);
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    int last_acc;

    checks    = 0;
    errors    = 0;
    det_count = 0;
    pos       = 0;
    in_frame  = 1'b0;
    det_hist  = 4'b0000;
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out", {30'd0, bus.out, bus.out_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.data_ready}, 32'd1);
    check("rst_flags", {30'd0, bus.out_stuff, bus.frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-payload of an AA frame
    push_frame(16'b10111010010100, 16'b00000001000010, 14);
    send(8'hAA);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", {30'd0, bus.out, bus.out_valid}, 32'd0);
    check("abort_ready", {31'd0, bus.data_ready}, 32'd1);
    check("abort_done", {31'd0, bus.frame_done}, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push_frame(16'b101100000000, 16'b000000000000, 12);
    send(8'h00);
    wait_drain();

    push_frame(16'b10111010100000, 16'b00000001010000, 14);
    send(8'hB0);
    wait_drain();

    push_frame(16'b10111010010100, 16'b00000001000010, 14);
    send(8'hAA);
    wait_drain();

    push_frame(16'b1011000001010, 16'b0000000000001, 13);
    send(8'h05);
    wait_drain();

    // Back-to-back with data_valid held and data_in scrambled mid-frame
    push_frame(16'b10111010100000, 16'b00000001010000, 14);
    push_frame(16'b101100000000, 16'b000000000000, 12);
    idx      = 0;
    cyc      = 0;
    last_acc = 0;
    for (int c = 0; c < 200 && idx < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.data_ready) begin
        if (idx == 2) begin
          bus.data_valid = 1'b0;
          idx = 3;
        end else begin
          bus.data_in    = (idx == 0) ? 8'hB0 : 8'h00;
          bus.data_valid = 1'b1;
          if (idx == 1)
            check("b2b_gap", cyc - last_acc, 32'd15);
          last_acc = cyc;
          idx++;
        end
      end else begin
        bus.data_in = 8'($urandom);
      end
    end
    bus.data_valid = 1'b0;
    check("b2b_complete", idx, 32'd3);
    wait_drain();

    repeat (3) @(posedge clk);
    check("detections", det_count, 32'd7);
    check("final_ready", {31'd0, bus.data_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
